// File: rtl/game_timer_bcd.sv
// rtl/game_timer_bcd.sv - prescaled N-digit BCD up/down game timer with saturation and expiry flags
// Optional lap capture register enabled by defining GAME_TIMER_LAP_EN.
module game_timer_bcd #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int DIGITS      = 3,
    parameter int PRE_W       = 26
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst_n,
    input  logic                  clr,
    input  logic                  run,
    input  logic                  freeze,
    input  logic                  dir,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
`ifdef GAME_TIMER_LAP_EN
    input  logic                  lap_cap,
    output logic [4*DIGITS-1:0]   lap_bcd,
`endif
    output logic [4*DIGITS-1:0]   time_bcd,
    output logic                  tick_1s,
    output logic                  time_max_flag,
    output logic                  time_zero_flag,
    output logic                  expired
);

    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
    localparam logic [4*DIGITS-1:0] ALL_NINES = {DIGITS{4'h9}};

    logic [PRE_W-1:0]    pre;
    logic [PRE_W-1:0]    next_pre;
    logic [4*DIGITS-1:0] inc_val;
    logic [4*DIGITS-1:0] dec_val;
    logic [4*DIGITS-1:0] clamp_val;
    logic [4*DIGITS-1:0] next_time;
    logic [3:0]          digit;
    logic [3:0]          load_digit;
    logic                carry;
    logic                borrow;
    logic                all_nines;
    logic                all_zeros;
    logic                next_tick;
    logic                next_expired;

    // Ripple increment/decrement of the current value plus per-digit clamp of the preload.
    always_comb begin
        inc_val    = time_bcd;
        dec_val    = time_bcd;
        clamp_val  = load_val;
        carry      = 1'b1;
        borrow     = 1'b1;
        all_nines  = 1'b1;
        all_zeros  = 1'b1;
        digit      = 4'd0;
        load_digit = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            digit      = time_bcd[4*i +: 4];
            load_digit = load_val[4*i +: 4];
            if (digit != 4'd9) begin
                all_nines = 1'b0;
            end
            if (digit != 4'd0) begin
                all_zeros = 1'b0;
            end
            if (carry) begin
                if (digit >= 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = digit + 4'd1;
                    carry = 1'b0;
                end
            end
            if (borrow) begin
                if (digit == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = digit - 4'd1;
                    borrow = 1'b0;
                end
            end
            if (load_digit > 4'd9) begin
                clamp_val[4*i +: 4] = 4'd9;
            end
        end
    end

    // Priority: clr > load > hold (freeze or pause) > prescaled step.
    always_comb begin
        next_time    = time_bcd;
        next_pre     = pre;
        next_tick    = 1'b0;
        next_expired = 1'b0;
        if (clr) begin
            next_time = '0;
            next_pre  = '0;
        end else if (load) begin
            next_time = clamp_val;
            next_pre  = '0;
        end else if (run && !freeze) begin
            if (pre == PRE_LAST) begin
                next_pre = '0;
                if (!dir && !all_nines) begin
                    next_time = inc_val;
                    next_tick = 1'b1;
                end else if (dir && !all_zeros) begin
                    next_time    = dec_val;
                    next_tick    = 1'b1;
                    next_expired = (dec_val == '0);
                end
            end else begin
                next_pre = pre + 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            pre            <= '0;
            time_bcd       <= '0;
            tick_1s        <= 1'b0;
            expired        <= 1'b0;
            time_max_flag  <= 1'b0;
            time_zero_flag <= 1'b1;
        end else begin
            pre            <= next_pre;
            time_bcd       <= next_time;
            tick_1s        <= next_tick;
            expired        <= next_expired;
            time_max_flag  <= (next_time == ALL_NINES);
            time_zero_flag <= (next_time == '0);
        end
    end

`ifdef GAME_TIMER_LAP_EN
    // Captures the value visible before this edge, so a coincident step is not included.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n || clr) begin
            lap_bcd <= '0;
        end else if (lap_cap) begin
            lap_bcd <= time_bcd;
        end
    end
`endif

endmodule

// File: tb/tb_game_timer_bcd.sv
// tb/tb_game_timer_bcd.sv - randomized and directed checks of game_timer_bcd against a decimal model
module tb_game_timer_bcd;

    localparam int TICK = 4;
    localparam int D    = 3;
    localparam int PW   = 3;
    localparam int MAXV = 999;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          run = 1'b0;
    logic          freeze = 1'b0;
    logic          dir = 1'b0;
    logic          load = 1'b0;
    logic [4*D-1:0] load_val = '0;
    logic          lap_cap = 1'b0;
    logic [4*D-1:0] time_bcd;
    logic          tick_1s;
    logic          time_max_flag;
    logic          time_zero_flag;
    logic          expired;
`ifdef GAME_TIMER_LAP_EN
    logic [4*D-1:0] lap_bcd;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int m_cnt = 0;
    int m_pre = 0;
    int m_lap = 0;
    bit m_tick = 0;
    bit m_exp = 0;
    bit chk_en = 0;

    game_timer_bcd #(.TICK_CYCLES(TICK), .DIGITS(D), .PRE_W(PW)) dut (
        .sys_clk(clk),
        .sys_rst_n(rst_n),
        .clr(clr),
        .run(run),
        .freeze(freeze),
        .dir(dir),
        .load(load),
        .load_val(load_val),
`ifdef GAME_TIMER_LAP_EN
        .lap_cap(lap_cap),
        .lap_bcd(lap_bcd),
`endif
        .time_bcd(time_bcd),
        .tick_1s(tick_1s),
        .time_max_flag(time_max_flag),
        .time_zero_flag(time_zero_flag),
        .expired(expired)
    );

    always #5 clk = ~clk;

    function automatic logic [4*D-1:0] to_bcd(input int v);
        logic [4*D-1:0] r;
        int p;
        r = '0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            r[4*i +: 4] = 4'((v / p) % 10);
            p = p * 10;
        end
        return r;
    endfunction

    function automatic int clamp_dec(input logic [4*D-1:0] lv);
        int v;
        int p;
        int d;
        v = 0;
        p = 1;
        for (int i = 0; i < D; i++) begin
            d = int'(lv[4*i +: 4]);
            if (d > 9) d = 9;
            v = v + d * p;
            p = p * 10;
        end
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Decimal-count model: what the timer must show after the edge given the inputs held across it.
    task automatic model_step();
        int old;
        old = m_cnt;
        m_tick = 0;
        m_exp = 0;
        if (!rst_n || clr) begin
            m_cnt = 0;
            m_pre = 0;
        end else if (load) begin
            m_cnt = clamp_dec(load_val);
            m_pre = 0;
        end else if (run && !freeze) begin
            if (m_pre == TICK - 1) begin
                m_pre = 0;
                if (!dir && m_cnt < MAXV) begin
                    m_cnt++;
                    m_tick = 1;
                end else if (dir && m_cnt > 0) begin
                    m_cnt--;
                    m_tick = 1;
                    m_exp = (m_cnt == 0);
                end
            end else begin
                m_pre++;
            end
        end
        if (!rst_n || clr) m_lap = 0;
        else if (lap_cap) m_lap = old;
    endtask

    task automatic cycle(input int n);
        repeat (n) begin
            @(posedge clk);
            model_step();
            chk_en = 1;
            #1;
        end
    endtask

    task automatic do_load(input logic [4*D-1:0] v);
        load = 1'b1;
        load_val = v;
        cycle(1);
        load = 1'b0;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("time_bcd", 32'(time_bcd), 32'(to_bcd(m_cnt)));
            chk("tick_1s", 32'(tick_1s), 32'(m_tick));
            chk("expired", 32'(expired), 32'(m_exp));
            chk("max_flag", 32'(time_max_flag), 32'(m_cnt == MAXV));
            chk("zero_flag", 32'(time_zero_flag), 32'(m_cnt == 0));
`ifdef GAME_TIMER_LAP_EN
            chk("lap_bcd", 32'(lap_bcd), 32'(to_bcd(m_lap)));
`endif
        end
    end

    initial begin
        cycle(2);
        chk("lit_reset_time", 32'(time_bcd), 32'h000);
        chk("lit_reset_zero", 32'(time_zero_flag), 32'd1);
        rst_n = 1'b1;

        run = 1'b1;
        cycle(40);
        chk("lit_40cyc_time", 32'(time_bcd), 32'h010);
        chk("lit_40cyc_tick", 32'(tick_1s), 32'd1);

        do_load(12'h099);
        cycle(4);
        chk("lit_double_carry", 32'(time_bcd), 32'h100);
        do_load(12'h998);
        cycle(8);
        chk("lit_sat_time", 32'(time_bcd), 32'h999);
        chk("lit_sat_flag", 32'(time_max_flag), 32'd1);
        cycle(12);
        chk("lit_sat_hold", 32'(time_bcd), 32'h999);

        do_load(12'h002);
        dir = 1'b1;
        cycle(7);
        chk("lit_before_expire", 32'(time_bcd), 32'h001);
        cycle(1);
        chk("lit_expired", 32'(expired), 32'd1);
        chk("lit_expire_zero", 32'(time_zero_flag), 32'd1);
        cycle(12);
        dir = 1'b0;
        cycle(4);
        chk("lit_resume_up", 32'(time_bcd), 32'h001);

        do_load(12'h000);
        cycle(2);
        freeze = 1'b1;
        cycle(10);
        chk("lit_frozen", 32'(time_bcd), 32'h000);
        freeze = 1'b0;
        cycle(2);
        chk("lit_after_freeze", 32'(time_bcd), 32'h001);

        cycle(3);
        clr = 1'b1;
        cycle(1);
        clr = 1'b0;
        chk("lit_clr_on_step", 32'(time_bcd), 32'h000);
        chk("lit_clr_no_tick", 32'(tick_1s), 32'd0);
        do_load(12'h9F3);
        chk("lit_clamp_load", 32'(time_bcd), 32'h993);

`ifdef GAME_TIMER_LAP_EN
        do_load(12'h007);
        lap_cap = 1'b1;
        cycle(1);
        lap_cap = 1'b0;
        chk("lit_lap", 32'(lap_bcd), 32'h007);
        cycle(4);
        chk("lit_lap_continue", 32'(time_bcd), 32'h008);
`endif

        for (int k = 0; k < 4000; k++) begin
            rst_n    = ($urandom_range(0, 299) != 0);
            clr      = ($urandom_range(0, 79) == 0);
            load     = ($urandom_range(0, 39) == 0);
            load_val = 12'($urandom);
            freeze   = ($urandom_range(0, 7) == 0);
            run      = ($urandom_range(0, 7) != 0);
            lap_cap  = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 23) == 0) dir = ~dir;
            cycle(1);
        end

        chk_en = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
